// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache.
// Holds the controller state enum, field widths and an address splitter.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    localparam int BITS_DEF  = 32;
    localparam int LINES_DEF = 8;
    localparam int WORDS_DEF = 4;

    localparam int OFS_W = $clog2(WORDS_DEF);
    localparam int IDX_W = $clog2(LINES_DEF);
    localparam int TAG_W = BITS_DEF - IDX_W - OFS_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFS_W-1:0] ofs;
    } addr_f_t;

    // Takes the word address (byte address without bits [1:0]).
    function automatic addr_f_t split_addr(input logic [BITS_DEF-3:0] wa);
        addr_f_t f;
        f.ofs = wa[OFS_W-1:0];
        f.idx = wa[OFS_W +: IDX_W];
        f.tag = wa[BITS_DEF-3 -: TAG_W];
        return f;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the cache: valid/dirty/tag/data per line.
// Ports: idx_i selects the line for both the combinational read
// (valid_o, dirty_o, tag_o, line_o) and the single write port
// (we_i word write at wofs_i, meta_we_i valid/dirty/tag write).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int OW    = $clog2(WORDS),
    parameter int IW    = $clog2(LINES),
    parameter int TW    = BITS - IW - OW - 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IW-1:0]               idx_i,
    input  logic                        we_i,
    input  logic [OW-1:0]               wofs_i,
    input  logic [BITS-1:0]             wdata_i,
    input  logic                        meta_we_i,
    input  logic                        valid_i,
    input  logic                        dirty_i,
    input  logic [TW-1:0]               tag_i,
    output logic                        valid_o,
    output logic                        dirty_o,
    output logic [TW-1:0]               tag_o,
    output logic [WORDS-1:0][BITS-1:0]  line_o
);

    logic [LINES-1:0]            valid_q;
    logic [LINES-1:0]            dirty_q;
    logic [TW-1:0]               tag_q  [LINES];
    logic [WORDS-1:0][BITS-1:0]  data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (we_i) begin
                data_q[idx_i][wofs_i] <= wdata_i;
            end
            if (meta_we_i) begin
                valid_q[idx_i] <= valid_i;
                dirty_q[idx_i] <= dirty_i;
                tag_q[idx_i]   <= tag_i;
            end
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Ports: proc_* processor data port (stall-based), mem_* word port to
// a single-cycle-read / posedge-write memory model.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            proc_ren,
    input  logic            proc_wen,
    input  logic [BITS-1:0] proc_addr,
    input  logic [BITS-1:0] proc_wdata,
    output logic [BITS-1:0] proc_rdata,
    output logic            proc_stall,
    output logic            mem_wen,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata
);

    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = BITS - IW - OW - 2;
    localparam logic [OW-1:0] CNT_LAST = OW'(WORDS - 1);

    state_e         state_q, state_d;
    logic [OW-1:0]  cnt_q, cnt_d;

    logic [TW-1:0]  req_tag;
    logic [IW-1:0]  idx;
    logic [OW-1:0]  ofs;
    logic           req;
    logic           hit;
    logic           last;
    logic           unused_addr;

    logic                        arr_we;
    logic [OW-1:0]               arr_wofs;
    logic [BITS-1:0]             arr_wdata;
    logic                        arr_meta_we;
    logic                        arr_dirty_i;
    logic                        line_valid;
    logic                        line_dirty;
    logic [TW-1:0]               line_tag;
    logic [WORDS-1:0][BITS-1:0]  line_data;

    assign req_tag     = proc_addr[BITS-1 -: TW];
    assign idx         = proc_addr[OW+2 +: IW];
    assign ofs         = proc_addr[2 +: OW];
    assign unused_addr = ^proc_addr[1:0];

    assign req  = proc_ren | proc_wen;
    assign hit  = req & line_valid & (line_tag == req_tag);
    assign last = (cnt_q == CNT_LAST);

    dcache_array #(
        .BITS  (BITS),
        .LINES (LINES),
        .WORDS (WORDS),
        .OW    (OW),
        .IW    (IW),
        .TW    (TW)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx_i     (idx),
        .we_i      (arr_we),
        .wofs_i    (arr_wofs),
        .wdata_i   (arr_wdata),
        .meta_we_i (arr_meta_we),
        .valid_i   (1'b1),
        .dirty_i   (arr_dirty_i),
        .tag_i     (req_tag),
        .valid_o   (line_valid),
        .dirty_o   (line_dirty),
        .tag_o     (line_tag),
        .line_o    (line_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        proc_stall  = 1'b0;
        proc_rdata  = '0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        arr_we      = 1'b0;
        arr_wofs    = ofs;
        arr_wdata   = proc_wdata;
        arr_meta_we = 1'b0;
        arr_dirty_i = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (hit) begin
                    // Write wins when both request lines are high.
                    if (proc_wen) begin
                        arr_we      = 1'b1;
                        arr_meta_we = 1'b1;
                    end else begin
                        proc_rdata = line_data[ofs];
                    end
                end else if (req) begin
                    proc_stall = 1'b1;
                    if (line_valid && line_dirty) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_wen    = 1'b1;
                mem_addr   = {line_tag, idx, cnt_q, 2'b00};
                mem_wdata  = line_data[cnt_q];
                cnt_d      = cnt_q + OW'(1);
                if (last) begin
                    state_d = S_ALLOCATE;
                    cnt_d   = '0;
                end
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_addr   = {req_tag, idx, cnt_q, 2'b00};
                arr_we     = 1'b1;
                arr_wofs   = cnt_q;
                arr_wdata  = mem_rdata;
                cnt_d      = cnt_q + OW'(1);
                // Line becomes valid only once the last word lands,
                // so an aborted refill never leaves a usable line.
                if (last) begin
                    arr_meta_we = 1'b1;
                    arr_dirty_i = 1'b0;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a word-wide memory model at 0x1000.
// Checks stall counts, memory traffic, read data and memory contents.
module tb_dcache_dm;

    logic        clk;
    logic        rst_n;
    logic        proc_ren;
    logic        proc_wen;
    logic [31:0] proc_addr;
    logic [31:0] proc_wdata;
    logic [31:0] proc_rdata;
    logic        proc_stall;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic        preload_req;

    int total;
    int bad;

    logic [31:0] la[$];
    logic [31:0] ld[$];
    logic        lw[$];
    logic        last_wen;

    dcache_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_ren   (proc_ren),
        .proc_wen   (proc_wen),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[31:10] == 22'h4) ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h100 + 32'(i);
        end else if (mem_wen && mem_addr[31:10] == 22'h4) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns after the request completes.
    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] rd);
        proc_ren   = r;
        proc_wen   = w;
        proc_addr  = a;
        proc_wdata = d;
        stalls = 0;
        la.delete();
        ld.delete();
        lw.delete();
        #1;
        while (proc_stall && stalls < 40) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
            lw.push_back(mem_wen);
            stalls++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        rd       = proc_rdata;
        last_wen = mem_wen;
        @(posedge clk);
        @(negedge clk);
        proc_ren = 1'b0;
        proc_wen = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        int          exp_st;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        proc_ren = 1'b0;
        proc_wen = 1'b0;
        proc_addr = '0;
        proc_wdata = '0;
        preload_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preload_req = 1'b0;
        #1;
        chk("rst_stall", 32'(proc_stall), 32'h0);
        chk("rst_mwen",  32'(mem_wen), 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdat", mem_wdata, 32'h0);
        chk("rst_rdata", proc_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // clean miss
        access(1, 0, 32'h1004, 0, st, rd);
        chk("miss_stall", 32'(st), 32'd5);
        chk("miss_a0", la[1], 32'h1000);
        chk("miss_a1", la[2], 32'h1004);
        chk("miss_a2", la[3], 32'h1008);
        chk("miss_a3", la[4], 32'h100C);
        chk("miss_w", 32'({lw[0], lw[1], lw[2], lw[3], lw[4]}), 32'h0);
        chk("miss_rd", rd, 32'h101);
        access(1, 0, 32'h1008, 0, st, rd);
        chk("hit_stall", 32'(st), 32'd0);
        chk("hit_rd", rd, 32'h102);

        // write hit
        access(0, 1, 32'h1004, 32'hDEADBEEF, st, rd);
        chk("wh_stall", 32'(st), 32'd0);
        chk("wh_mwen", 32'(last_wen), 32'h0);
        access(1, 0, 32'h1004, 0, st, rd);
        chk("wh_rd", rd, 32'hDEADBEEF);
        chk("wh_mem1", mem[1], 32'h101);

        // dirty eviction
        access(1, 0, 32'h1084, 0, st, rd);
        chk("ev_stall", 32'(st), 32'd9);
        chk("ev_w", 32'({lw[1], lw[2], lw[3], lw[4]}), 32'hF);
        chk("ev_wa0", la[1], 32'h1000);
        chk("ev_wa3", la[4], 32'h100C);
        chk("ev_wd0", ld[1], 32'h100);
        chk("ev_wd1", ld[2], 32'hDEADBEEF);
        chk("ev_wd3", ld[4], 32'h103);
        chk("ev_r", 32'({lw[5], lw[6], lw[7], lw[8]}), 32'h0);
        chk("ev_ra0", la[5], 32'h1080);
        chk("ev_ra3", la[8], 32'h108C);
        chk("ev_rd", rd, 32'h121);
        chk("ev_mem1", mem[1], 32'hDEADBEEF);

        // write miss
        access(0, 1, 32'h1010, 32'h55, st, rd);
        chk("wm_stall", 32'(st), 32'd5);
        chk("wm_a0", la[1], 32'h1010);
        chk("wm_a3", la[4], 32'h101C);
        access(1, 0, 32'h1010, 0, st, rd);
        chk("wm_stall2", 32'(st), 32'd0);
        chk("wm_rd", rd, 32'h55);
        chk("wm_mem4", mem[4], 32'h104);
        access(1, 0, 32'h1090, 0, st, rd);
        chk("wm_ev_stall", 32'(st), 32'd9);
        chk("wm_ev_rd", rd, 32'h124);
        chk("wm_mem4b", mem[4], 32'h55);

        // reset during the second refill cycle
        proc_ren  = 1'b1;
        proc_addr = 32'h1020;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("ra_stall_pre", 32'(proc_stall), 32'h1);
        chk("ra_addr_pre", mem_addr, 32'h1024);
        rst_n    = 1'b0;
        proc_ren = 1'b0;
        #1;
        chk("ra_stall", 32'(proc_stall), 32'h0);
        chk("ra_mwen", 32'(mem_wen), 32'h0);
        chk("ra_maddr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1, 0, 32'h1020, 0, st, rd);
        chk("ra_re_stall", 32'(st), 32'd5);
        chk("ra_re_a0", la[1], 32'h1020);
        chk("ra_re_a3", la[4], 32'h102C);
        chk("ra_re_rd", rd, 32'h108);

        // hit sweep over a freshly preloaded memory
        preload_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preload_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // index 2 is still resident from the re-read above
            exp_st = (i == 2) ? 0 : 5;
            access(1, 0, 32'h1000 + 32'(16 * i), 0, st, rd);
            chk($sformatf("fill%0d", i), 32'(st), 32'(exp_st));
        end
        for (int k = 0; k < 32; k++) begin
            access(1, 0, 32'h1000 + 32'(4 * k), 0, st, rd);
            chk($sformatf("sw_st%0d", k), 32'(st), 32'd0);
            chk($sformatf("sw_rd%0d", k), rd, 32'h100 + 32'(k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
